// File: rtl/sp_ram_be_clr.sv
// Single-port synchronous RAM with per-byte write enables, registered read data
// and a clear sequencer that initialises every word after reset or on command.
module sp_ram_be_clr #(
   parameter int                    ADDR_WIDTH = 6,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    DEPTH      = 64,
   parameter int                    RDW_MODE   = 0,
   parameter logic [DATA_WIDTH-1:0] CLR_VALUE  = '0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req,
   input  logic                    we,
   input  logic [DATA_WIDTH/8-1:0] be,
   input  logic [ADDR_WIDTH-1:0]   addr,
   input  logic [DATA_WIDTH-1:0]   data,
   output logic [DATA_WIDTH-1:0]   q,
   output logic                    q_valid,
   output logic                    addr_err,
   output logic                    busy,
   input  logic                    clr_start,
   output logic                    clr_done
);

   localparam int BE_W  = DATA_WIDTH / 8;
   localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   if (DATA_WIDTH % 8 != 0) begin : g_bad_data_width
      $error("sp_ram_be_clr: DATA_WIDTH must be a multiple of 8");
   end
   if (DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
      $error("sp_ram_be_clr: DEPTH exceeds the address space");
   end

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_e;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      clr_cnt_q, clr_cnt_d;
   logic [DATA_WIDTH-1:0] q_q, q_d;
   logic                  q_valid_q, q_valid_d;
   logic                  addr_err_q, addr_err_d;
   logic                  clr_done_q, clr_done_d;

   logic                  in_range;
   logic [CNT_W-1:0]      mem_idx;
   logic                  mem_we;
   logic [CNT_W-1:0]      mem_waddr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [BE_W-1:0]       mem_wbe;

   assign in_range = (int'(addr) < DEPTH);
   assign mem_idx  = addr[CNT_W-1:0];

   always_comb begin
      state_d    = state_q;
      clr_cnt_d  = clr_cnt_q;
      q_d        = q_q;
      q_valid_d  = 1'b0;
      addr_err_d = 1'b0;
      clr_done_d = 1'b0;
      mem_we     = 1'b0;
      mem_waddr  = clr_cnt_q;
      mem_wdata  = CLR_VALUE;
      mem_wbe    = '1;

      case (state_q)
         ST_CLEAR: begin
            // Requests and clr_start are ignored; one word is cleared per cycle.
            mem_we = 1'b1;
            if (clr_cnt_q == CNT_W'(DEPTH - 1)) begin
               state_d    = ST_IDLE;
               clr_done_d = 1'b1;
               clr_cnt_d  = '0;
            end else begin
               clr_cnt_d = clr_cnt_q + CNT_W'(1);
            end
         end
         ST_IDLE: begin
            if (req) begin
               addr_err_d = ~in_range;
               if (we) begin
                  mem_we    = in_range;
                  mem_waddr = mem_idx;
                  mem_wdata = data;
                  mem_wbe   = be;
               end else begin
                  q_valid_d = 1'b1;
                  q_d       = in_range ? mem[mem_idx] : '0;
               end
            end
            // The access above is still serviced; the clear starts on the next edge.
            if (clr_start) begin
               state_d   = ST_CLEAR;
               clr_cnt_d = '0;
            end
         end
         default: begin
            state_d   = ST_CLEAR;
            clr_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_CLEAR;
         clr_cnt_q  <= '0;
         q_q        <= '0;
         q_valid_q  <= 1'b0;
         addr_err_q <= 1'b0;
         clr_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_cnt_q  <= clr_cnt_d;
         q_q        <= q_d;
         q_valid_q  <= q_valid_d;
         addr_err_q <= addr_err_d;
         clr_done_q <= clr_done_d;
      end
   end

   // Storage has no reset; the clear sequencer initialises it.
   always_ff @(posedge clk) begin
      if (rst_n && mem_we) begin
         for (int i = 0; i < BE_W; i++) begin
            if (mem_wbe[i]) begin
               mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
         end
      end
   end

   assign q        = q_q;
   assign q_valid  = q_valid_q;
   assign addr_err = addr_err_q;
   assign clr_done = clr_done_q;
   assign busy     = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_sp_ram_be_clr.sv
// Bench for sp_ram_be_clr: a 64-word and a 48-word instance share one stimulus
// stream and are checked every cycle against a word-array reference model.
module tb_sp_ram_be_clr;

   logic        clk = 1'b0;
   logic        rst_n, req, we, clr_start;
   logic [3:0]  be;
   logic [5:0]  addr;
   logic [31:0] data;

   logic [31:0] q_a, q_b;
   logic        qv_a, qv_b, ae_a, ae_b, busy_a, busy_b, done_a, done_b;

   always #5 clk = ~clk;

   sp_ram_be_clr #(
      .ADDR_WIDTH(6), .DATA_WIDTH(32), .DEPTH(64), .RDW_MODE(0), .CLR_VALUE(32'h0)
   ) u_dut_a (
      .clk(clk), .rst_n(rst_n), .req(req), .we(we), .be(be), .addr(addr), .data(data),
      .q(q_a), .q_valid(qv_a), .addr_err(ae_a), .busy(busy_a),
      .clr_start(clr_start), .clr_done(done_a)
   );

   sp_ram_be_clr #(
      .ADDR_WIDTH(6), .DATA_WIDTH(32), .DEPTH(48), .RDW_MODE(1), .CLR_VALUE(32'h5A5A0F0F)
   ) u_dut_b (
      .clk(clk), .rst_n(rst_n), .req(req), .we(we), .be(be), .addr(addr), .data(data),
      .q(q_b), .q_valid(qv_b), .addr_err(ae_b), .busy(busy_b),
      .clr_start(clr_start), .clr_done(done_b)
   );

   // Reference model: index 0 = 64-word instance, index 1 = 48-word instance.
   int          depth_m [2] = '{64, 48};
   logic [31:0] clr_m   [2] = '{32'h0, 32'h5A5A0F0F};
   logic [31:0] mem_m   [2][64];
   int          clr_left[2];
   logic [31:0] q_m     [2];
   logic        qv_m    [2], ae_m[2], done_m[2];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic model_edge(input int k);
      qv_m[k]   = 1'b0;
      ae_m[k]   = 1'b0;
      done_m[k] = 1'b0;
      if (!rst_n) begin
         clr_left[k] = depth_m[k];
         q_m[k]      = 32'h0;
      end else if (clr_left[k] > 0) begin
         mem_m[k][depth_m[k] - clr_left[k]] = clr_m[k];
         clr_left[k]--;
         done_m[k] = (clr_left[k] == 0);
      end else begin
         if (req) begin
            if (int'(addr) >= depth_m[k]) begin
               ae_m[k] = 1'b1;
               if (!we) begin
                  q_m[k]  = 32'h0;
                  qv_m[k] = 1'b1;
               end
            end else if (we) begin
               for (int i = 0; i < 4; i++)
                  if (be[i]) mem_m[k][addr][8*i +: 8] = data[8*i +: 8];
            end else begin
               q_m[k]  = mem_m[k][addr];
               qv_m[k] = 1'b1;
            end
         end
         if (clr_start) clr_left[k] = depth_m[k];
      end
   endtask

   task automatic cyc(input logic r, input logic w, input logic [3:0] b, input logic [5:0] a,
                      input logic [31:0] d, input logic cs, input logic rn);
      req = r; we = w; be = b; addr = a; data = d; clr_start = cs; rst_n = rn;
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      #1;
      check("a.q",        q_a,    q_m[0]);
      check("a.q_valid",  qv_a,   qv_m[0]);
      check("a.addr_err", ae_a,   ae_m[0]);
      check("a.busy",     busy_a, clr_left[0] > 0);
      check("a.clr_done", done_a, done_m[0]);
      check("b.q",        q_b,    q_m[1]);
      check("b.q_valid",  qv_b,   qv_m[1]);
      check("b.addr_err", ae_b,   ae_m[1]);
      check("b.busy",     busy_b, clr_left[1] > 0);
      check("b.clr_done", done_b, done_m[1]);
   endtask

   task automatic idle_cycles(input int n, output int busy_cnt_a, output int busy_cnt_b,
                              output int done_cnt_a, output int done_cnt_b);
      busy_cnt_a = 0; busy_cnt_b = 0; done_cnt_a = 0; done_cnt_b = 0;
      for (int i = 0; i < n; i++) begin
         if (busy_a) busy_cnt_a++;
         if (busy_b) busy_cnt_b++;
         cyc(1'b0, 1'b0, 4'h0, 6'd0, 32'h0, 1'b0, 1'b1);
         if (done_a) done_cnt_a++;
         if (done_b) done_cnt_b++;
      end
   endtask

   initial begin
      int ba, bb, da, db, bad;
      req = 0; we = 0; be = 0; addr = 0; data = 0; clr_start = 0; rst_n = 0;

      // Reset and the initial clear.
      cyc(0, 0, 4'h0, 6'd0, 32'h0, 0, 0);
      cyc(1, 0, 4'h0, 6'd3, 32'h0, 1, 0);
      check("rst.q", q_a, 32'h0);
      check("rst.busy", busy_a, 1'b1);
      idle_cycles(70, ba, bb, da, db);
      check("init.busy_cycles_a", ba, 64);
      check("init.busy_cycles_b", bb, 48);
      check("init.done_pulses_a", da, 1);
      check("init.done_pulses_b", db, 1);
      foreach (depth_m[k]) begin end
      cyc(1, 0, 4'h0, 6'd0, 32'h0, 0, 1);
      check("init.rd0.q", q_a, 32'h0);
      check("init.rd0.qv", qv_a, 1'b1);
      cyc(1, 0, 4'h0, 6'd1, 32'h0, 0, 1);
      check("init.rd1.q", q_a, 32'h0);
      cyc(1, 0, 4'h0, 6'd63, 32'h0, 0, 1);
      check("init.rd63.q", q_a, 32'h0);
      check("init.rd63.qv", qv_a, 1'b1);
      cyc(0, 0, 4'h0, 6'd0, 32'h0, 0, 1);
      check("init.qv_drop", qv_a, 1'b0);

      // Byte-enable merge.
      cyc(1, 1, 4'b1111, 6'd5, 32'hAABBCCDD, 0, 1);
      cyc(1, 1, 4'b0101, 6'd5, 32'h11223344, 0, 1);
      cyc(1, 1, 4'b0000, 6'd5, 32'hFFFFFFFF, 0, 1);
      check("be.write_keeps_q", q_a, 32'h0);
      cyc(1, 0, 4'h0, 6'd5, 32'h0, 0, 1);
      check("be.merge_a", q_a, 32'hAA22CC44);
      check("be.merge_b", q_b, 32'hAA22CC44);

      // Back-to-back writes then reads.
      for (int i = 0; i < 3; i++) cyc(1, 1, 4'hF, 6'(i), 32'(i + 1), 0, 1);
      for (int i = 0; i < 3; i++) begin
         cyc(1, 0, 4'h0, 6'(i), 32'h0, 0, 1);
         check("b2b.q", q_a, 32'(i + 1));
         check("b2b.qv", qv_a, 1'b1);
      end

      // Clear on command; a read in the clr_start cycle is still serviced.
      cyc(1, 1, 4'hF, 6'd10, 32'hDEADBEEF, 0, 1);
      cyc(1, 0, 4'h0, 6'd10, 32'h0, 1, 1);
      check("clr.same_cycle_rd", q_a, 32'hDEADBEEF);
      check("clr.busy", busy_a, 1'b1);
      bad = 0;
      for (int i = 0; i < 70; i++) begin
         logic was_busy;
         was_busy = busy_a;
         cyc(1, 0, 4'h0, 6'd10, 32'h0, 1'($urandom_range(0, 1)), 1);
         if (was_busy && qv_a) bad++;
         if (!busy_a) break;
      end
      check("clr.no_qv_while_busy", bad, 0);
      cyc(1, 0, 4'h0, 6'd10, 32'h0, 0, 1);
      check("clr.rd10_a", q_a, 32'h0);
      check("clr.rd10_b", q_b, 32'h5A5A0F0F);

      // Reset 20 cycles into a clear restarts it from the beginning.
      cyc(0, 0, 4'h0, 6'd0, 32'h0, 1, 1);
      for (int i = 0; i < 20; i++) cyc(0, 0, 4'h0, 6'd0, 32'h0, 0, 1);
      cyc(1, 0, 4'h0, 6'd1, 32'h0, 0, 0);
      check("rstmid.no_qv", qv_a, 1'b0);
      idle_cycles(70, ba, bb, da, db);
      check("rstmid.busy_cycles_a", ba, 64);
      check("rstmid.busy_cycles_b", bb, 48);
      check("rstmid.done_pulses_a", da, 1);

      // Out-of-range accesses on the 48-word instance.
      cyc(1, 1, 4'hF, 6'd50, 32'hFF, 0, 1);
      check("oor.wr_ae_b", ae_b, 1'b1);
      check("oor.wr_ae_a", ae_a, 1'b0);
      check("oor.wr_qv_b", qv_b, 1'b0);
      cyc(1, 0, 4'h0, 6'd50, 32'h0, 0, 1);
      check("oor.rd_q_b", q_b, 32'h0);
      check("oor.rd_qv_b", qv_b, 1'b1);
      check("oor.rd_ae_b", ae_b, 1'b1);
      check("oor.rd_q_a", q_a, 32'hFF);
      cyc(1, 0, 4'h0, 6'd47, 32'h0, 0, 1);
      check("oor.rd47_q_b", q_b, 32'h5A5A0F0F);
      check("oor.rd47_ae_b", ae_b, 1'b0);

      // Randomised traffic with occasional clears and resets.
      for (int i = 0; i < 600; i++) begin
         cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 4'($urandom),
             6'($urandom), $urandom, 1'($urandom_range(0, 59) == 0),
             1'($urandom_range(0, 299) != 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
